// File: rtl/div16by8_seq.sv
// div16by8_seq -- sequential 16/8 unsigned divider (radix-2 restoring, one
// quotient bit per clock). Recovers A from P = A*B in the multiplier
// characterization flow and flags quotients wider than 8 bits.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid            in_ready   block can accept operands
//   P [15:0]   dividend                  B [7:0]    divisor
//   out_valid  result valid              out_ready  sink accepts result
//   Q [15:0]   quotient                  R [7:0]    remainder
//   div_zero   B was 0 for this result
//   ovf        Q[15:8] != 0 (P is not B times any 8-bit A)
//
// Timing: accept edge captures operands, the next edge primes the datapath,
// then 16 iteration edges; out_valid rises 17 edges after accept. B == 0
// bypasses the iterations and reaches DONE on the accept edge itself.

module div16by8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] P,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        div_zero,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;

  // Working shift register: dividend bits leave at the MSB while quotient
  // bits enter at the LSB, so after 16 iterations it holds the quotient.
  logic [15:0] work_reg;
  logic [7:0]  div_reg;
  logic [7:0]  rem_reg;
  logic [3:0]  cnt_reg;
  logic        primed_reg;

  logic        in_ready_reg;
  logic        out_valid_reg;
  logic [15:0] q_reg;
  logic [7:0]  r_reg;
  logic        div_zero_reg;
  logic        ovf_reg;

  // One restoring step. The trial value is 9 bits wide only so the compare
  // sees the bit shifted out of the remainder; after a successful subtract
  // the result is below the divisor, so 8-bit modular subtraction is exact.
  logic [8:0]  trial;
  logic        qbit;
  logic [7:0]  rem_next;
  logic [15:0] work_next;

  assign trial     = {rem_reg, work_reg[15]};
  assign qbit      = (trial >= {1'b0, div_reg});
  assign rem_next  = qbit ? (trial[7:0] - div_reg) : trial[7:0];
  assign work_next = {work_reg[14:0], qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      div_reg       <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      primed_reg    <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      r_reg         <= '0;
      div_zero_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_ready_reg <= 1'b0;
            work_reg     <= P;
            div_reg      <= B;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            primed_reg   <= 1'b0;
            if (B == 8'd0) begin
              // Divide by zero: saturated quotient, dividend low byte as
              // remainder, both flags set.
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              q_reg         <= 16'hFFFF;
              r_reg         <= P[7:0];
              div_zero_reg  <= 1'b1;
              ovf_reg       <= 1'b1;
            end else begin
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          if (!primed_reg) begin
            // Load cycle between accept and the first iteration.
            primed_reg <= 1'b1;
          end else begin
            work_reg <= work_next;
            rem_reg  <= rem_next;
            cnt_reg  <= cnt_reg + 4'd1;
            if (cnt_reg == 4'd15) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              q_reg         <= work_next;
              r_reg         <= rem_next;
              div_zero_reg  <= 1'b0;
              ovf_reg       <= |work_next[15:8];
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign Q         = q_reg;
  assign R         = r_reg;
  assign div_zero  = div_zero_reg;
  assign ovf       = ovf_reg;

endmodule
